// File: rtl/eer_rl_pkg.sv
// Shared EER-RL constants: data width, packet-type codes and reward-generator FSM states.
package eer_rl_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int IDX_WIDTH  = 6;

    localparam logic [2:0] PKT_NONE   = 3'd0;
    localparam logic [2:0] PKT_HB     = 3'd1;
    localparam logic [2:0] PKT_CHE    = 3'd2;
    localparam logic [2:0] PKT_INV    = 3'd3;
    localparam logic [2:0] PKT_DATA   = 3'd4;
    localparam logic [2:0] PKT_REWARD = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BUILD = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reward_pkt_gen_if.sv
// Neighbor-table read port: the reward generator drives the index, the table returns the entry.
interface reward_pkt_gen_if;
    import eer_rl_pkg::*;

    logic [IDX_WIDTH-1:0]  nTableIndex_reward;
    logic [WORD_WIDTH-1:0] mNodeID;
    logic [WORD_WIDTH-1:0] mNodeHops;
    logic [WORD_WIDTH-1:0] mNodeQValue;
    logic [WORD_WIDTH-1:0] mNodeEnergy;
    logic [WORD_WIDTH-1:0] mNodeCHHops;

    modport master (
        output nTableIndex_reward,
        input  mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops
    );

    modport slave (
        input  nTableIndex_reward,
        output mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops
    );

endinterface

// File: rtl/reward_qmax_scan.sv
// Neighbor-table walker: index counter plus running maximum of the Q-values read back.
module reward_qmax_scan
    import eer_rl_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clear,
    input  logic                  step,
    input  logic [WORD_WIDTH-1:0] q,
    input  logic [4:0]            count,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic [WORD_WIDTH-1:0] best,
    output logic                  last
);

    always_ff @(posedge clk) begin
        if (nrst || clear) begin
            idx  <= '0;
            best <= '0;
        end else if (step) begin
            // strict compare keeps the earliest entry on ties
            if (q > best)
                best <= q;
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == (IDX_WIDTH'(count) - 1'b1));

endmodule

// File: rtl/reward_pkt_gen.sv
// Reward packet generator: scans neighbor Q-values and registers the EER-RL reward fields.
// Optional REWARD_LOW_ENERGY_GUARD_EN: low_E at build time advertises a Q-value of 0.
//
//  state | meaning
//  IDLE  | waiting for en
//  SCAN  | walking neighbor table, tracking max Q
//  BUILD | registering reward fields (or nothing for a non-trigger)
//  DONE  | reward_done high, fields valid
module reward_pkt_gen
    import eer_rl_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [2:0]            fPacketType,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic                  iHaveData,
    input  logic                  iAmDestination,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic                  role,
    input  logic                  low_E,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenHop,
    input  logic [4:0]            neighborCount,
    reward_pkt_gen_if.master      nbr,
    output logic [WORD_WIDTH-1:0] rSourceID,
    output logic [WORD_WIDTH-1:0] rEnergyLeft,
    output logic [WORD_WIDTH-1:0] rQValue,
    output logic [WORD_WIDTH-1:0] rSourceHops,
    output logic [WORD_WIDTH-1:0] rDestinationID,
    output logic [WORD_WIDTH-1:0] rChosenCH,
    output logic [WORD_WIDTH-1:0] rHopsFromCH,
    output logic [2:0]            rPacketType,
    output logic                  reward_done
);

    state_t                state, state_nxt;
    logic                  trig;
    logic                  build_q;
    logic [4:0]            count_q;
    logic [IDX_WIDTH-1:0]  scan_idx;
    logic [WORD_WIDTH-1:0] scan_best;
    logic                  scan_last;
    logic                  scan_clear;
    logic                  scan_step;
    logic [WORD_WIDTH-1:0] q_sel;
    logic                  unused_inputs;

    assign unused_inputs = ^{iHaveData, low_E, nbr.mNodeID, nbr.mNodeHops,
                             nbr.mNodeEnergy, nbr.mNodeCHHops};

    assign trig       = en && (fPacketType == PKT_DATA) && iAmDestination;
    assign scan_clear = (state == ST_IDLE) && en;
    assign scan_step  = (state == ST_SCAN);

    assign nbr.nTableIndex_reward = scan_step ? scan_idx : '0;

    reward_qmax_scan u_scan (
        .clk   (clk),
        .nrst  (nrst),
        .clear (scan_clear),
        .step  (scan_step),
        .q     (nbr.mNodeQValue),
        .count (count_q),
        .idx   (scan_idx),
        .best  (scan_best),
        .last  (scan_last)
    );

    always_ff @(posedge clk) begin
        if (nrst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // non-trigger requests also pass through BUILD so both paths finish two edges after en
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en) state_nxt = (trig && (neighborCount != '0)) ? ST_SCAN : ST_BUILD;
            ST_SCAN:  if (scan_last) state_nxt = ST_BUILD;
            ST_BUILD: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        q_sel = (count_q != '0) ? scan_best : myQValue;
`ifdef REWARD_LOW_ENERGY_GUARD_EN
        if (low_E)
            q_sel = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            build_q        <= 1'b0;
            count_q        <= '0;
            rSourceID      <= '0;
            rEnergyLeft    <= '0;
            rQValue        <= '0;
            rSourceHops    <= '0;
            rDestinationID <= '0;
            rChosenCH      <= '0;
            rHopsFromCH    <= '0;
            rPacketType    <= PKT_NONE;
            reward_done    <= 1'b0;
        end else begin
            reward_done <= (state == ST_BUILD);
            if ((state == ST_IDLE) && en) begin
                build_q <= trig;
                count_q <= trig ? neighborCount : '0;
                if (!trig)
                    rPacketType <= PKT_NONE;
            end
            if ((state == ST_BUILD) && build_q) begin
                rSourceID      <= myNodeID;
                rEnergyLeft    <= myEnergy;
                rSourceHops    <= hopsFromSink;
                rDestinationID <= chosenHop;
                rPacketType    <= PKT_REWARD;
                rQValue        <= q_sel;
                rChosenCH      <= role ? myNodeID : chosenCH;
                rHopsFromCH    <= role ? '0 : hopsFromCH;
            end
        end
    end

endmodule

// File: tb/tb_reward_pkt_gen.sv
// Bench for reward_pkt_gen: directed scenarios plus random requests against a field-level reward model.
module tb_reward_pkt_gen;
    import eer_rl_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [2:0]  fPacketType;
    logic [15:0] myEnergy;
    logic        iHaveData;
    logic        iAmDestination;
    logic [15:0] myNodeID, hopsFromSink, myQValue;
    logic        role, low_E;
    logic [15:0] chosenCH, hopsFromCH, chosenHop;
    logic [4:0]  neighborCount;
    logic [15:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
    logic [2:0]  rPacketType;
    logic        reward_done;

    reward_pkt_gen_if nbr();

    logic [15:0] tbl_q [0:63];

    assign nbr.mNodeQValue = tbl_q[nbr.nTableIndex_reward];
    assign nbr.mNodeID     = 16'(nbr.nTableIndex_reward) + 16'h0100;
    assign nbr.mNodeHops   = 16'(nbr.nTableIndex_reward) + 16'h0002;
    assign nbr.mNodeEnergy = 16'hA000;
    assign nbr.mNodeCHHops = 16'h0001;

    reward_pkt_gen dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .fPacketType    (fPacketType),
        .myEnergy       (myEnergy),
        .iHaveData      (iHaveData),
        .iAmDestination (iAmDestination),
        .myNodeID       (myNodeID),
        .hopsFromSink   (hopsFromSink),
        .myQValue       (myQValue),
        .role           (role),
        .low_E          (low_E),
        .chosenCH       (chosenCH),
        .hopsFromCH     (hopsFromCH),
        .chosenHop      (chosenHop),
        .neighborCount  (neighborCount),
        .nbr            (nbr),
        .rSourceID      (rSourceID),
        .rEnergyLeft    (rEnergyLeft),
        .rQValue        (rQValue),
        .rSourceHops    (rSourceHops),
        .rDestinationID (rDestinationID),
        .rChosenCH      (rChosenCH),
        .rHopsFromCH    (rHopsFromCH),
        .rPacketType    (rPacketType),
        .reward_done    (reward_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference copy of the registered reward fields
    logic [15:0] m_src, m_energy, m_q, m_hops, m_dst, m_ch, m_chhops;
    logic [2:0]  m_ptype;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_src = '0; m_energy = '0; m_q = '0; m_hops = '0;
        m_dst = '0; m_ch = '0; m_chhops = '0; m_ptype = PKT_NONE;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rSourceID"},      rSourceID,      m_src);
        chk({tag, ".rEnergyLeft"},    rEnergyLeft,    m_energy);
        chk({tag, ".rQValue"},        rQValue,        m_q);
        chk({tag, ".rSourceHops"},    rSourceHops,    m_hops);
        chk({tag, ".rDestinationID"}, rDestinationID, m_dst);
        chk({tag, ".rChosenCH"},      rChosenCH,      m_ch);
        chk({tag, ".rHopsFromCH"},    rHopsFromCH,    m_chhops);
        chk({tag, ".rPacketType"},    rPacketType,    m_ptype);
        chk({tag, ".index"},          nbr.nTableIndex_reward, 0);
        chk({tag, ".reward_done"},    reward_done,    0);
    endtask

    // Issues one en strobe with the current inputs, watches the handshake, then updates the model.
    task automatic run_op(input string tag, input bit reen);
        bit          trig;
        int          n, lat, done_edge, pulses, idx_bad;
        logic [15:0] qmax;
        trig = (fPacketType == PKT_DATA) && iAmDestination;
        n    = trig ? int'(neighborCount) : 0;
        lat  = n + 2;
        qmax = '0;
        for (int i = 0; i < n; i++)
            if (tbl_q[i] > qmax) qmax = tbl_q[i];
        done_edge = 0; pulses = 0; idx_bad = 0;
        en = 1'b1;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (k == 1) en = 1'b0;
            if (reen && k == 2) en = 1'b1;
            if (reen && k == 3) en = 1'b0;
            if (reward_done === 1'b1) begin
                pulses++;
                if (done_edge == 0) done_edge = k;
            end
            if (nbr.nTableIndex_reward !== ((k <= n) ? 6'(k - 1) : 6'd0)) idx_bad++;
        end
        if (trig) begin
            m_src    = myNodeID;
            m_energy = myEnergy;
            m_hops   = hopsFromSink;
            m_dst    = chosenHop;
            m_ptype  = PKT_REWARD;
            m_q      = (n > 0) ? qmax : myQValue;
`ifdef REWARD_LOW_ENERGY_GUARD_EN
            if (low_E) m_q = '0;
`endif
            m_ch     = role ? myNodeID : chosenCH;
            m_chhops = role ? 16'd0 : hopsFromCH;
        end else begin
            m_ptype = PKT_NONE;
        end
        chk({tag, ".done_edge"},  done_edge, lat);
        chk({tag, ".done_pulses"}, pulses,   1);
        chk({tag, ".scan_index"}, idx_bad,   0);
        check_outputs(tag);
    endtask

    task automatic set_node(input logic [15:0] id, input logic [15:0] energy, input logic [15:0] hop);
        myNodeID = id; myEnergy = energy; chosenHop = hop;
    endtask

    initial begin
        int pulses;
        nrst = 1'b1; en = 1'b0; fPacketType = PKT_NONE; myEnergy = '0; iHaveData = 1'b0;
        iAmDestination = 1'b0; myNodeID = '0; hopsFromSink = '0; myQValue = '0;
        role = 1'b0; low_E = 1'b0; chosenCH = '0; hopsFromCH = '0; chosenHop = '0;
        neighborCount = '0;
        for (int i = 0; i < 64; i++) tbl_q[i] = '0;
        model_reset();

        repeat (2) @(negedge clk);
        nrst = 1'b0;
        check_outputs("reset");

        hopsFromSink = 16'd1;
        fPacketType  = PKT_HB;
        run_op("hb", 1'b0);

        tbl_q[0] = 16'd5; tbl_q[1] = 16'd9; tbl_q[2] = 16'd7;
        fPacketType = PKT_DATA; iAmDestination = 1'b1; neighborCount = 5'd3;
        set_node(16'h000C, 16'h8000, 16'h0003);
        chosenCH = 16'h0021; hopsFromCH = 16'h0002; myQValue = 16'h0011;
        run_op("scan3", 1'b0);

        neighborCount = 5'd0; myQValue = 16'h0040;
        run_op("empty", 1'b0);

        role = 1'b1; neighborCount = 5'd2;
        run_op("head", 1'b0);

        low_E = 1'b1;
        run_op("lowE", 1'b0);
        low_E = 1'b0; role = 1'b0;

        iAmDestination = 1'b0;
        run_op("notdest", 1'b0);
        iAmDestination = 1'b1;

        // ties and the top entry of a full table
        for (int i = 0; i < 31; i++) tbl_q[i] = 16'h0100;
        tbl_q[30] = 16'hFFFF;
        neighborCount = 5'd31;
        run_op("full", 1'b0);

        neighborCount = 5'd6;
        run_op("reen", 1'b1);

        neighborCount = 5'd10;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
        check_outputs("midrst");
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (reward_done === 1'b1) pulses++;
        end
        chk("midrst.no_done", pulses, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 32; i++) tbl_q[i] = 16'($urandom_range(0, 15) * 16'h0111);
            fPacketType    = ($urandom_range(0, 3) != 0) ? PKT_DATA : 3'($urandom_range(0, 7));
            iAmDestination = ($urandom_range(0, 3) != 0);
            neighborCount  = 5'($urandom_range(0, 31));
            set_node(16'($urandom), 16'($urandom), 16'($urandom));
            hopsFromSink   = 16'($urandom);
            myQValue       = 16'($urandom);
            chosenCH       = 16'($urandom);
            hopsFromCH     = 16'($urandom);
            role           = 1'($urandom_range(0, 1));
            low_E          = 1'($urandom_range(0, 1));
            iHaveData      = 1'($urandom_range(0, 1));
            run_op("rand", 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
